fpmul_pipe: RTL and testbench

//  Pipelined IEEE-754 binary32 multiplier (odat = mdat1 * mdat2) with round-to-nearest-even.

---
 rtl/fpmul_pipe.sv | 137 +++++++++++++
 tb/tb_fpmul_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_pipe.sv
// Three-stage pipelined binary32 multiplier, round-to-nearest-even, DAZ/FTZ.
// Optional FPMUL_FLAGS_EN adds flags[3:0] = {invalid, overflow, underflow, inexact}.
module fpmul_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned DW = 1 + EXP_W + MAN_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] mdat1,
  input  logic [DW-1:0] mdat2,
  output logic [DW-1:0] odat
`ifdef FPMUL_FLAGS_EN
  ,
  output logic [3:0]    flags
`endif
);

  localparam int unsigned SW      = MAN_W + 1;
  localparam int unsigned PW      = 2 * SW;
  localparam int unsigned EW2     = EXP_W + 2;
  localparam int unsigned BIAS    = 2**(EXP_W-1) - 1;
  localparam int unsigned EXP_MAX = 2**EXP_W - 1;

  // Stage 1 operand classification
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

  assign exp_a  = mdat1[DW-2 -: EXP_W];
  assign exp_b  = mdat2[DW-2 -: EXP_W];
  assign frac_a = mdat1[MAN_W-1:0];
  assign frac_b = mdat2[MAN_W-1:0];
  assign nan_a  = (&exp_a) & (|frac_a);
  assign nan_b  = (&exp_b) & (|frac_b);
  assign inf_a  = (&exp_a) & ~(|frac_a);
  assign inf_b  = (&exp_b) & ~(|frac_b);
  assign zero_a = (exp_a == '0);
  assign zero_b = (exp_b == '0);

  logic             s1_sign, s1_invalid, s1_inf, s1_zero;
  logic [EXP_W-1:0] s1_exp_a, s1_exp_b;
  logic [SW-1:0]    s1_sig_a, s1_sig_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_sign    <= 1'b0;
      s1_invalid <= 1'b0;
      s1_inf     <= 1'b0;
      s1_zero    <= 1'b0;
      s1_exp_a   <= '0;
      s1_exp_b   <= '0;
      s1_sig_a   <= '0;
      s1_sig_b   <= '0;
    end else begin
      s1_sign    <= mdat1[DW-1] ^ mdat2[DW-1];
      s1_invalid <= nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a);
      s1_inf     <= inf_a | inf_b;
      s1_zero    <= zero_a | zero_b;
      s1_exp_a   <= exp_a;
      s1_exp_b   <= exp_b;
      s1_sig_a   <= {1'b1, frac_a};
      s1_sig_b   <= {1'b1, frac_b};
    end
  end

  // Stage 2: mantissa product and biased exponent sum
  logic           s2_sign, s2_invalid, s2_inf, s2_zero;
  logic [EW2-1:0] s2_exp;
  logic [PW-1:0]  s2_prod;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_sign    <= 1'b0;
      s2_invalid <= 1'b0;
      s2_inf     <= 1'b0;
      s2_zero    <= 1'b0;
      s2_exp     <= '0;
      s2_prod    <= '0;
    end else begin
      s2_sign    <= s1_sign;
      s2_invalid <= s1_invalid;
      s2_inf     <= s1_inf;
      s2_zero    <= s1_zero;
      s2_exp     <= EW2'(s1_exp_a) + EW2'(s1_exp_b) - EW2'(BIAS);
      s2_prod    <= PW'(s1_sig_a) * PW'(s1_sig_b);
    end
  end

  // Stage 3: normalize, round, range-check and pack
  logic [PW-2:0]    p_n;
  logic [MAN_W-1:0] man, man_r;
  logic [MAN_W:0]   rnd;
  logic             guard, sticky, round_up;
  logic [EW2-1:0]   exp_n, exp_r;
  logic             ovf, unf;
  logic [DW-1:0]    res;

  always_comb begin
    p_n      = s2_prod[PW-1] ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
    exp_n    = s2_exp + EW2'(s2_prod[PW-1]);
    man      = p_n[PW-2 -: MAN_W];
    guard    = p_n[PW-2-MAN_W];
    sticky   = |p_n[PW-3-MAN_W:0];
    round_up = guard & (sticky | man[0]);
    rnd      = {1'b0, man} + (MAN_W+1)'(round_up);
    man_r    = rnd[MAN_W-1:0];
    exp_r    = exp_n + EW2'(rnd[MAN_W]);
    ovf      = ~exp_r[EW2-1] & (exp_r >= EW2'(EXP_MAX));
    unf      = exp_r[EW2-1] | (exp_r == '0);
    res      = {s2_sign, exp_r[EXP_W-1:0], man_r};
    if (s2_invalid)   res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    else if (s2_inf)  res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (s2_zero) res = {s2_sign, {(DW-1){1'b0}}};
    else if (ovf)     res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (unf)     res = {s2_sign, {(DW-1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) odat <= '0;
    else        odat <= res;
  end

`ifdef FPMUL_FLAGS_EN
  logic normal_c;
  assign normal_c = ~s2_invalid & ~s2_inf & ~s2_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) flags <= '0;
    else flags <= {s2_invalid,
                   normal_c & ovf,
                   normal_c & ~ovf & unf,
                   normal_c & (guard | sticky | ovf | unf)};
  end
`endif

endmodule

// File: tb/tb_fpmul_pipe.sv
// Scoreboard bench for fpmul_pipe: directed vectors, a short random stream, and mid-stream reset.
module tb_fpmul_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mdat1, mdat2, odat;
  logic        issue;
`ifdef FPMUL_FLAGS_EN
  logic [3:0]  flags;
`endif

  always #5 clk = ~clk;

  fpmul_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mdat1 (mdat1),
    .mdat2 (mdat2),
    .odat  (odat)
`ifdef FPMUL_FLAGS_EN
    ,
    .flags (flags)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } item_t;

  item_t sb_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // Independent integer reference: leading-one shift, remainder-vs-half rounding
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, e, sh;
    logic [47:0] p, q, rem, half;
    logic        na, nb, ia, ib, za, zb;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    za = (ea == 0);
    zb = (eb == 0);
    if (na || nb || (ia && zb) || (ib && za)) return 32'h7FC00000;
    if (ia || ib) return {s, 8'hFF, 23'd0};
    if (za || zb) return {s, 31'd0};
    p    = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    sh   = p[47] ? 24 : 23;
    e    = ea + eb - 127 + (p[47] ? 1 : 0);
    q    = p >> sh;
    rem  = p & ((48'd1 << sh) - 48'd1);
    half = 48'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 48'd1;
    if (q[24]) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_normal();
    return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: odat=%08h expected=%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    item_t it;
    @(negedge clk);
    mdat1 = a;
    mdat2 = b;
    issue = 1'b1;
    it.a = a;
    it.b = b;
    it.e = e;
    sb_q.push_back(it);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      mdat1 = 32'h0;
      mdat2 = 32'h0;
      issue = 1'b0;
    end
  endtask

  // Monitor: tracks issue slots through a 3-deep shadow and compares at the output slot
  initial begin : monitor
    logic [2:0] vp;
    logic       s_issue, s_rst;
    item_t      it;
    vp = 3'b000;
    forever begin
      @(posedge clk);
      s_issue = issue;
      s_rst   = rst_n;
      #1;
      if (!s_rst) begin
        vp = 3'b000;
        sb_q.delete();
        check("reset_zero", odat, 32'h0);
      end else begin
        vp = {vp[1:0], s_issue};
        if (vp[2]) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_underflow: odat=%08h expected=<none>", odat);
          end else begin
            it = sb_q.pop_front();
            check($sformatf("mul_%08h_x_%08h", it.a, it.b), odat, it.e);
          end
        end else begin
          check("idle_zero", odat, 32'h0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [31:0] dir_a [13];
  logic [31:0] dir_b [13];
  logic [31:0] dir_e [13];

  initial begin : stim
    logic [31:0] ra, rb;
    dir_a = '{32'h3F800000, 32'h3FC00000, 32'hC0400000, 32'hBF800000, 32'h3F800001,
              32'h3FFFFFFF, 32'h7F7FFFFF, 32'h00800000, 32'h00000001, 32'h7F800000,
              32'h7FC00001, 32'hFF800000, 32'h40400000};
    dir_b = '{32'h40000000, 32'h3FC00000, 32'h40800000, 32'h80000000, 32'h3F800001,
              32'h3FFFFFFF, 32'h40000000, 32'h00800000, 32'h3F800000, 32'h00000000,
              32'h3F800000, 32'h40000000, 32'hFF800000};
    dir_e = '{32'h40000000, 32'h40100000, 32'hC1400000, 32'h00000000, 32'h3F800002,
              32'h407FFFFE, 32'h7F800000, 32'h00000000, 32'h00000000, 32'h7FC00000,
              32'h7FC00000, 32'hFF800000, 32'hFF800000};

    rst_n = 1'b0;
    mdat1 = 32'h0;
    mdat2 = 32'h0;
    issue = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Single isolated vector: exact 3-edge latency, zeros around it
    drive(dir_a[0], dir_b[0], dir_e[0]);
    idle(5);

    for (int i = 0; i < 13; i++) drive(dir_a[i], dir_b[i], dir_e[i]);
    idle(5);

    for (int i = 0; i < 10; i++) begin
      ra = rand_normal();
      rb = rand_normal();
      drive(ra, rb, ref_mul(ra, rb));
    end
    idle(5);

    // Mid-stream reset on the sixth cycle of a stream
    for (int i = 0; i < 5; i++) begin
      ra = rand_normal();
      rb = rand_normal();
      drive(ra, rb, ref_mul(ra, rb));
    end
    @(negedge clk);
    rst_n = 1'b0;
    mdat1 = 32'h40400000;
    mdat2 = 32'h40400000;
    issue = 1'b0;
    @(negedge clk);
    mdat1 = 32'h3FC00000;
    @(negedge clk);
    rst_n = 1'b1;
    mdat1 = 32'h0;
    mdat2 = 32'h0;
    idle(3);

    drive(32'h3FC00000, 32'h3FC00000, 32'h40100000);
    for (int i = 0; i < 4; i++) begin
      ra = rand_normal();
      rb = rand_normal();
      drive(ra, rb, ref_mul(ra, rb));
    end
    idle(6);

    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: pending=%0d expected=0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
